pdm_decoder: RTL

//  Receive-side counterpart of the pdm encoder: converts a 1-bit PDM stream (pin or internal
//  pdm dout) back into WIDTH-bit PCM samples by boxcar-decimating over 2^DECIM_LOG2 input samples.

---
 rtl/pdm_decoder_if.sv | 26 ++
 rtl/pdm_decoder.sv | 113 +++++++++++
 2 files changed

// File: rtl/pdm_decoder_if.sv
// Sample output channel of the PDM decoder: registered PCM sample with a
// valid/ready handshake plus the sticky overrun flag.
interface pdm_decoder_if #(
    parameter int unsigned WIDTH = 10
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;
    logic             overrun;

    // Producer side (the decoder)
    modport master (
        output data,
        output valid,
        output overrun,
        input  ready
    );

    // Consumer side (readback logic)
    modport slave (
        input  data,
        input  valid,
        input  overrun,
        output ready
    );
endinterface

// File: rtl/pdm_decoder.sv
// PDM decoder: synchronises a 1-bit PDM stream, counts ones over a boxcar window of
// 2^DECIM_LOG2 divided-clock samples and publishes the scaled, saturated count as a
// WIDTH-bit PCM sample through a valid/ready channel with a sticky overrun flag.
module pdm_decoder #(
    parameter int unsigned WIDTH       = 10,
    parameter int unsigned DECIM_LOG2  = 10,
    parameter int unsigned CLKDIV      = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_pdm_in,
    pdm_decoder_if.master o_pcm
);

    localparam int unsigned DivW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLKDIV - 1);

    // Synchroniser
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_bit;

    // Sample divider and window state
    logic [DivW-1:0]       r_div;
    logic [DECIM_LOG2-1:0] r_win_cnt;
    logic [DECIM_LOG2:0]   r_acc;
    logic                  w_tick;
    logic                  w_win_end;
    logic [DECIM_LOG2:0]   w_sum;
    logic [WIDTH-1:0]      w_res;

    // Output channel state
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;
    logic             w_xfer;

    assign w_bit = r_sync[SYNC_STAGES-1];

    // Synchroniser shift register; keeps running while decoding is disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pdm_in};
        end
    end

    // A tick marks the cycle on which one synchronised bit enters the window
    assign w_tick    = i_en && (r_div == DivLast);
    assign w_win_end = w_tick && (r_win_cnt == '1);
    // Ones count including the bit accepted on this tick
    assign w_sum     = r_acc + {{DECIM_LOG2{1'b0}}, w_bit};

    // Divider counts 0..CLKDIV-1; held at zero while disabled so enable starts a full period
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DivW'(1);
        end
    end

    // Window position and running ones count; disable discards a partial window
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_win_cnt <= '0;
            r_acc     <= '0;
        end else if (w_tick) begin
            r_win_cnt <= r_win_cnt + DECIM_LOG2'(1);
            r_acc     <= w_win_end ? '0 : w_sum;
        end
    end

    // Scale the window count to WIDTH bits by truncation; only a full all-ones window can
    // reach 2^WIDTH, which is clipped to full scale.
    if (DECIM_LOG2 >= WIDTH) begin : g_scale_down
        logic [DECIM_LOG2:0] w_shifted;
        assign w_shifted = w_sum >> (DECIM_LOG2 - WIDTH);
        assign w_res     = (|w_shifted[DECIM_LOG2:WIDTH]) ? '1 : w_shifted[WIDTH-1:0];
    end else begin : g_scale_up
        logic [WIDTH:0] w_shifted;
        assign w_shifted = {w_sum, {(WIDTH - DECIM_LOG2){1'b0}}};
        assign w_res     = w_shifted[WIDTH] ? '1 : w_shifted[WIDTH-1:0];
    end

    assign w_xfer = r_valid && o_pcm.ready;

    // Output register and handshake; a new sample always wins, losing an untaken one is flagged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_win_end) begin
            r_data  <= w_res;
            r_valid <= 1'b1;
            if (r_valid && !o_pcm.ready) begin
                r_overrun <= 1'b1;
            end
        end else if (w_xfer) begin
            r_valid <= 1'b0;
        end
    end

    assign o_pcm.data    = r_data;
    assign o_pcm.valid   = r_valid;
    assign o_pcm.overrun = r_overrun;

endmodule
